// File: rtl/memu_pkg.sv
// Shared types for the memory access unit: funct3 size codes, FSM states and
// the small decode helpers used by memu and memu_align.
package memu_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        MEMU_IDLE = 2'd0,
        MEMU_REQ  = 2'd1,
        MEMU_RESP = 2'd2,
        MEMU_DONE = 2'd3
    } memu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // Reserved codes (011, 110, 111) land in the word bucket.
    function automatic mem_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [1:0] mask_lo(input mem_size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/memu_align.sv
// Byte-lane steering: store strobes/replicated data from (funct3, a[1:0], valB)
// and the extended load value from (funct3, a[1:0], rdata). Purely combinational.
module memu_align
    import memu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       a_lo,
    input  logic [WIDTH-1:0] val_b,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       wstrb,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] val_m
);

    logic [WIDTH-1:0] rsh;
    logic             sext;

    always_comb begin
        rsh   = rdata >> {a_lo, 3'b000};
        sext  = ~funct3[2];
        wstrb = 4'b0000;
        wdata = '0;
        val_m = '0;
        case (size_of(funct3))
            SZ_B: begin
                wstrb = 4'b0001 << a_lo;
                wdata = {4{val_b[7:0]}};
                val_m = {{24{sext & rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                wstrb = 4'b0011 << a_lo;
                wdata = {2{val_b[15:0]}};
                val_m = {{16{sext & rsh[15]}}, rsh[15:0]};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = val_b;
                val_m = rdata;
            end
        endcase
    end

endmodule

// File: rtl/memu.sv
// Multi-cycle load/store unit: IDLE -> REQ -> RESP -> DONE over a valid/ready bus.
// Optional MEMU_MISALIGN_TRAP_EN turns misaligned H/W accesses into a bus-less trap.
module memu
    import memu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CTRL_i_start,
    input  logic             CTRL_i_mem_wr,
    input  logic [2:0]       CTRL_i_funct3,
    input  logic [WIDTH-1:0] EXU_i_valE,
    input  logic [WIDTH-1:0] IDU_i_valB,
    output logic             MEMU_o_req_valid,
    input  logic             MEMU_i_req_ready,
    output logic [WIDTH-1:0] MEMU_o_addr,
    output logic             MEMU_o_we,
    output logic [3:0]       MEMU_o_wstrb,
    output logic [WIDTH-1:0] MEMU_o_wdata,
    input  logic             MEMU_i_rsp_valid,
    input  logic [WIDTH-1:0] MEMU_i_rdata,
    output logic             MEMU_o_rsp_ready,
    output logic [WIDTH-1:0] MEMU_o_valM,
    output logic             MEMU_o_done,
    output logic             MEMU_o_busy,
    output logic             MEMU_o_misalign,
    output logic [1:0]       MEMU_o_dbg_state
);

    // Bus handshake: a beat transfers on any rising edge where valid && ready;
    // request fields hold steady from the cycle after start until that beat.

    memu_state_e      state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [1:0]       a_lo_q, a_lo_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             we_q, we_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] valm_q, valm_d;

    mem_size_e        in_sz;
    logic [1:0]       in_lo;
    logic [2:0]       al_funct3;
    logic [1:0]       al_lo;
    logic [3:0]       al_wstrb;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_valm;

    // In IDLE the aligner sees the incoming request; afterwards it sees the latched one.
    always_comb begin
        in_sz     = size_of(CTRL_i_funct3);
        in_lo     = mask_lo(in_sz, EXU_i_valE[1:0]);
        al_funct3 = (state_q == MEMU_IDLE) ? CTRL_i_funct3 : funct3_q;
        al_lo     = (state_q == MEMU_IDLE) ? in_lo : a_lo_q;
    end

    memu_align #(.WIDTH(WIDTH)) u_align (
        .funct3 (al_funct3),
        .a_lo   (al_lo),
        .val_b  (IDU_i_valB),
        .rdata  (MEMU_i_rdata),
        .wstrb  (al_wstrb),
        .wdata  (al_wdata),
        .val_m  (al_valm)
    );

`ifdef MEMU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic in_mis;
    always_comb begin
        in_mis = ((in_sz == SZ_H) && EXU_i_valE[0]) ||
                 ((in_sz == SZ_W) && (EXU_i_valE[1:0] != 2'b00));
    end
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        a_lo_d   = a_lo_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        valm_d   = valm_q;
`ifdef MEMU_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            MEMU_IDLE: begin
                if (CTRL_i_start) begin
                    addr_d   = {EXU_i_valE[WIDTH-1:2], 2'b00};
                    a_lo_d   = in_lo;
                    funct3_d = CTRL_i_funct3;
                    we_d     = CTRL_i_mem_wr;
                    wstrb_d  = al_wstrb;
                    wdata_d  = al_wdata;
                    state_d  = MEMU_REQ;
`ifdef MEMU_MISALIGN_TRAP_EN
                    mis_d    = in_mis;
                    if (in_mis) begin
                        wstrb_d = 4'b0000;
                        state_d = MEMU_DONE;
                    end
`endif
                end
            end
            MEMU_REQ: begin
                if (MEMU_i_req_ready) state_d = MEMU_RESP;
            end
            MEMU_RESP: begin
                if (MEMU_i_rsp_valid) begin
                    if (!we_q) valm_d = al_valm;
                    state_d = MEMU_DONE;
                end
            end
            default: begin
                state_d = MEMU_IDLE;
`ifdef MEMU_MISALIGN_TRAP_EN
                mis_d   = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MEMU_IDLE;
            addr_q   <= '0;
            a_lo_q   <= 2'b00;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= '0;
            valm_q   <= '0;
`ifdef MEMU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            a_lo_q   <= a_lo_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            valm_q   <= valm_d;
`ifdef MEMU_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    assign MEMU_o_req_valid = (state_q == MEMU_REQ);
    assign MEMU_o_rsp_ready = (state_q == MEMU_RESP);
    assign MEMU_o_done      = (state_q == MEMU_DONE);
    assign MEMU_o_busy      = (state_q != MEMU_IDLE);
    assign MEMU_o_addr      = addr_q;
    assign MEMU_o_we        = we_q;
    assign MEMU_o_wstrb     = wstrb_q;
    assign MEMU_o_wdata     = wdata_q;
    assign MEMU_o_valM      = valm_q;
    assign MEMU_o_dbg_state = state_q;
`ifdef MEMU_MISALIGN_TRAP_EN
    assign MEMU_o_misalign  = (state_q == MEMU_DONE) && mis_q;
`else
    assign MEMU_o_misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_memu.sv
// Self-checking bench for memu: directed test-plan cases plus randomized
// load/store traffic against a byte-arithmetic reference model.
module tb_memu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] val_e;
    logic [31:0] val_b;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_ready;
    logic [31:0] val_m;
    logic        done;
    logic        busy;
    logic        misalign;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_valm = 32'h0;

    memu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .CTRL_i_start     (start),
        .CTRL_i_mem_wr    (mem_wr),
        .CTRL_i_funct3    (funct3),
        .EXU_i_valE       (val_e),
        .IDU_i_valB       (val_b),
        .MEMU_o_req_valid (req_valid),
        .MEMU_i_req_ready (req_ready),
        .MEMU_o_addr      (addr),
        .MEMU_o_we        (we),
        .MEMU_o_wstrb     (wstrb),
        .MEMU_o_wdata     (wdata),
        .MEMU_i_rsp_valid (rsp_valid),
        .MEMU_i_rdata     (rdata),
        .MEMU_o_rsp_ready (rsp_ready),
        .MEMU_o_valM      (val_m),
        .MEMU_o_done      (done),
        .MEMU_o_busy      (busy),
        .MEMU_o_misalign  (misalign),
        .MEMU_o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: access size in bytes, effective lane, lane arithmetic
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int eff_lo(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int lo;
        n  = nbytes(f3);
        lo = int'(a % 4);
        return lo - (lo % n);
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << eff_lo(f3, a);
        return 4'(m);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] b);
        case (nbytes(f3))
            1:       return (b % 256) * 32'h0101_0101;
            2:       return (b % 65536) * 32'h0001_0001;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [63:0] p;
        logic [63:0] full;
        int          n;
        n    = nbytes(f3);
        full = 64'd1 << (8 * n);
        p    = {32'h0, rd} >> (8 * eff_lo(f3, a));
        p    = p % full;
        if ((f3 == 3'b000 || f3 == 3'b001) && p >= (full / 2)) p = p - full;
        return p[31:0];
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
        return (nbytes(f3) == 2 && a[0]) || (nbytes(f3) == 4 && a[1:0] != 2'b00);
    endfunction

    // driver: one full transaction with bus-side wait states
    task automatic do_txn(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd,
                          input int req_wait, input int rsp_wait, input logic poke_start);
        logic [31:0] exp_v;
        check({name, "_idle_busy"}, busy, 0);
        start  = 1'b1;
        mem_wr = wr;
        funct3 = f3;
        val_e  = a;
        val_b  = b;
        step();
        start  = 1'b0;
        val_e  = $urandom;
        val_b  = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        exp_v  = wr ? model_valm : exp_load(f3, a, rd);
`ifdef MEMU_MISALIGN_TRAP_EN
        if (is_mis(f3, a)) begin
            check({name, "_trap_req_valid"}, req_valid, 0);
            check({name, "_trap_done"}, done, 1);
            check({name, "_trap_misalign"}, misalign, 1);
            check({name, "_trap_valm"}, val_m, model_valm);
            step();
            check({name, "_trap_done_drop"}, done, 0);
            check({name, "_trap_busy_drop"}, busy, 0);
            return;
        end
`endif
        exp_q.push_back(exp_v);
        for (int i = 0; i <= req_wait; i++) begin
            check({name, "_req_valid"}, req_valid, 1);
            check({name, "_req_busy"}, busy, 1);
            check({name, "_req_rsp_ready"}, rsp_ready, 0);
            check({name, "_addr"}, addr, {a[31:2], 2'b00});
            check({name, "_we"}, we, wr);
            if (wr) begin
                check({name, "_wstrb"}, wstrb, exp_strb(f3, a));
                check({name, "_wdata"}, wdata, exp_wdata(f3, b));
            end
            req_ready = (i == req_wait);
            rsp_valid = 1'($urandom_range(0, 1));
            rdata     = $urandom;
            if (poke_start && i == 0) begin
                start  = 1'b1;
                mem_wr = 1'($urandom_range(0, 1));
                val_e  = $urandom;
            end
            step();
            start = 1'b0;
        end
        for (int i = 0; i <= rsp_wait; i++) begin
            check({name, "_rsp_ready"}, rsp_ready, 1);
            check({name, "_rsp_req_valid"}, req_valid, 0);
            check({name, "_rsp_done"}, done, 0);
            req_ready = 1'($urandom_range(0, 1));
            rsp_valid = (i == rsp_wait);
            rdata     = (i == rsp_wait) ? rd : $urandom;
            if (poke_start) start = 1'b1;
            step();
            start = 1'b0;
        end
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_done_misalign"}, misalign, 0);
        check({name, "_done_rsp_ready"}, rsp_ready, 0);
        check({name, "_valm"}, val_m, exp_q.pop_front());
        model_valm = exp_v;
        step();
        check({name, "_done_drop"}, done, 0);
        check({name, "_busy_drop"}, busy, 0);
        check({name, "_valm_hold"}, val_m, model_valm);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_req_valid"}, req_valid, 0);
        check({name, "_rsp_ready"}, rsp_ready, 0);
        check({name, "_done"}, done, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_misalign"}, misalign, 0);
        check({name, "_we"}, we, 0);
        check({name, "_addr"}, addr, 0);
        check({name, "_wstrb"}, wstrb, 0);
        check({name, "_wdata"}, wdata, 0);
        check({name, "_valm"}, val_m, 0);
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst_n = 1'b0;
        start = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        val_e = 32'h0; val_b = 32'h0;
        req_ready = 1'b0; rsp_valid = 1'b0; rdata = 32'h0;
        #12;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        do_txn("lw",  1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        do_txn("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 0, 1'b0);
        do_txn("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 0, 1'b0);
        do_txn("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h1234_5678, 0, 0, 1'b0);
        do_txn("bp",  1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'hC0DE_8001, 3, 2, 1'b1);
        do_txn("lw_mis", 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);

        // abort a load in RESP with an asynchronous reset
        start = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; val_e = 32'h0000_4444;
        step();
        start = 1'b0;
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("abort_in_resp", rsp_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        model_valm = 32'h0;
        step();
        rst_n = 1'b1;
        rsp_valid = 1'b1;
        rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        rsp_valid = 1'b0;
        do_txn("post_rst", 1'b0, 3'b001, 32'h0000_5006, 32'h0, 32'h9ABC_1234, 1, 1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            do_txn("rand", 1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)],
                   $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
